seg7_counter_ctrl: RTL and testbench

Run/pause/step controller for the 7-segment counter datapath. It turns button-style command levels into a counting schedule, using a programmable prescaler to set the count rate. It holds the current digit and drives registered segment, decimal-point and status outputs. It sits between the dedicated input pins and the segment output pins inside the top-level counter project.

---
 rtl/seg7_counter_ctrl_if.sv | 30 +++
 rtl/seg7_counter_ctrl.sv | 144 ++++++++++++++
 tb/tb_seg7_counter_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/seg7_counter_ctrl_if.sv
// Control/status bundle between the counter controller and its surroundings.
//   master : drives the enable, command, direction and rate inputs; reads status.
//   slave  : the controller itself.
// Signals:
//   ena, cmd_start, cmd_stop, cmd_step, cmd_clear, dir_up, rate_sel[2:0]  (to controller)
//   digit[3:0], seg[6:0], dp, running, wrap_pulse                         (from controller)
interface seg7_counter_ctrl_if;
  logic       ena;
  logic       cmd_start;
  logic       cmd_stop;
  logic       cmd_step;
  logic       cmd_clear;
  logic       dir_up;
  logic [2:0] rate_sel;
  logic [3:0] digit;
  logic [6:0] seg;
  logic       dp;
  logic       running;
  logic       wrap_pulse;

  modport master (
    output ena, cmd_start, cmd_stop, cmd_step, cmd_clear, dir_up, rate_sel,
    input  digit, seg, dp, running, wrap_pulse
  );

  modport slave (
    input  ena, cmd_start, cmd_stop, cmd_step, cmd_clear, dir_up, rate_sel,
    output digit, seg, dp, running, wrap_pulse
  );
endinterface

// File: rtl/seg7_counter_ctrl.sv
// Run/pause/step controller for a single 7-segment counter digit.
// Command levels are edge-detected, a programmable prescaler paces counting
// while running, and digit/segment/status outputs are all registered.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - seg7_counter_ctrl_if.slave: ena, cmd_*, dir_up, rate_sel in;
//          digit, seg, dp, running, wrap_pulse out
module seg7_counter_ctrl #(
  parameter int BASE_DIV   = 1000,
  parameter int PRESCALE_W = 24,
  parameter int MAX_DIGIT  = 9
) (
  input  logic                clk,
  input  logic                rst,
  seg7_counter_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

  localparam logic [3:0] MAXD = 4'(MAX_DIGIT);

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_cmd_hist;
  logic [3:0]            w_cmd, w_edge;
  logic [PRESCALE_W-1:0] r_cnt, w_cnt_nxt, w_term;
  logic [3:0]            r_digit, w_digit_nxt;
  logic [6:0]            r_seg;
  logic                  r_dp, r_run, r_wrap;
  logic                  w_wrap, w_adv, w_cnt_en;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'h0: seg_decode = 7'h3F;  4'h1: seg_decode = 7'h06;
      4'h2: seg_decode = 7'h5B;  4'h3: seg_decode = 7'h4F;
      4'h4: seg_decode = 7'h66;  4'h5: seg_decode = 7'h6D;
      4'h6: seg_decode = 7'h7D;  4'h7: seg_decode = 7'h07;
      4'h8: seg_decode = 7'h7F;  4'h9: seg_decode = 7'h6F;
      4'hA: seg_decode = 7'h77;  4'hB: seg_decode = 7'h7C;
      4'hC: seg_decode = 7'h39;  4'hD: seg_decode = 7'h5E;
      4'hE: seg_decode = 7'h79;  default: seg_decode = 7'h71;
    endcase
  endfunction

  // Bit order: [3]=clear [2]=stop [1]=start [0]=step (descending priority).
  // Edges are masked by ena so a frozen block sees no commands at all; the
  // history still tracks the levels, so a level held across ena rising is stale.
  assign w_cmd  = {bus.cmd_clear, bus.cmd_stop, bus.cmd_start, bus.cmd_step};
  assign w_edge = w_cmd & ~r_cmd_hist & {4{bus.ena}};

  assign w_term = (PRESCALE_W'(BASE_DIV) << bus.rate_sel) - PRESCALE_W'(1);

  // Counting is suppressed on a cycle where clear or stop wins, so stop
  // leaves the prescaler exactly where it was. Start/step in RUN are no-ops.
  assign w_cnt_en = bus.ena && (r_state == RUN) && !(w_edge[3] || w_edge[2]);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_digit_nxt = r_digit;
    w_wrap      = 1'b0;
    w_adv       = 1'b0;

    if (w_edge[3]) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_digit_nxt = 4'd0;
    end else if (w_edge[2]) begin
      if (r_state == RUN) w_state_nxt = PAUSED;
    end else if (w_edge[1]) begin
      if (r_state != RUN) begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end
    end else if (w_edge[0]) begin
      if (r_state != RUN) begin
        w_state_nxt = PAUSED;
        w_adv       = 1'b1;
      end
    end

    // >= so a shortened period fires at once when the count is already past it.
    if (w_cnt_en) begin
      if (r_cnt >= w_term) begin
        w_cnt_nxt = '0;
        w_adv     = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + PRESCALE_W'(1);
      end
    end

    if (w_adv) begin
      if (bus.dir_up) begin
        if (r_digit >= MAXD) begin
          w_digit_nxt = 4'd0;
          w_wrap      = 1'b1;
        end else begin
          w_digit_nxt = r_digit + 4'd1;
        end
      end else begin
        if (r_digit == 4'd0) begin
          w_digit_nxt = MAXD;
          w_wrap      = 1'b1;
        end else begin
          w_digit_nxt = r_digit - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // seg/dp/running are taken from next-state values so they line up with
  // digit and state on the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_hist <= '0;
      r_cnt      <= '0;
      r_digit    <= 4'd0;
      r_seg      <= 7'h3F;
      r_dp       <= 1'b0;
      r_run      <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_cmd_hist <= w_cmd;
      r_cnt      <= w_cnt_nxt;
      r_digit    <= w_digit_nxt;
      r_seg      <= seg_decode(w_digit_nxt);
      r_dp       <= (w_state_nxt == PAUSED);
      r_run      <= (w_state_nxt == RUN);
      r_wrap     <= w_wrap;
    end
  end

  assign bus.digit      = r_digit;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.running    = r_run;
  assign bus.wrap_pulse = r_wrap;

endmodule

// File: tb/tb_seg7_counter_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed expected outputs tagged with
// the cycle they must appear on; a negedge monitor pops and compares.
module tb_seg7_counter_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  seg7_counter_ctrl_if bus();

  seg7_counter_ctrl #(.BASE_DIV(4), .PRESCALE_W(24), .MAX_DIGIT(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] d;
    logic       dp;
    logic       run;
    logic       wrap;
    string      tag;
  } exp_t;

  exp_t q[$];

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0: seg_of = 7'h3F;  4'h1: seg_of = 7'h06;  4'h2: seg_of = 7'h5B;
      4'h3: seg_of = 7'h4F;  4'h4: seg_of = 7'h66;  4'h5: seg_of = 7'h6D;
      4'h6: seg_of = 7'h7D;  4'h7: seg_of = 7'h07;  4'h8: seg_of = 7'h7F;
      4'h9: seg_of = 7'h6F;  4'hA: seg_of = 7'h77;  4'hB: seg_of = 7'h7C;
      4'hC: seg_of = 7'h39;  4'hD: seg_of = 7'h5E;  4'hE: seg_of = 7'h79;
      default: seg_of = 7'h71;
    endcase
  endfunction

  task automatic exp_at(input int c, input int d, input logic dp, input logic run,
                        input logic wrap, input string tag);
    exp_t e;
    e.cyc = c; e.d = 4'(d); e.dp = dp; e.run = run; e.wrap = wrap; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic go_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: outputs are sampled at the falling edge, away from the active edge.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [13:0] act, req;
      e = q.pop_front();
      checks++;
      act = {bus.digit, bus.seg, bus.dp, bus.running, bus.wrap_pulse};
      req = {e.d, seg_of(e.d), e.dp, e.run, e.wrap};
      if (e.cyc < cyc) begin
        failures++;
        $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d", e.tag, e.cyc, cyc);
      end else if (act !== req) begin
        failures++;
        $display("FAIL %s @cyc %0d: got digit=%0d seg=%h dp=%b run=%b wrap=%b, want digit=%0d seg=%h dp=%b run=%b wrap=%b",
                 e.tag, cyc, bus.digit, bus.seg, bus.dp, bus.running, bus.wrap_pulse,
                 e.d, seg_of(e.d), e.dp, e.run, e.wrap);
      end
    end
  end

  logic [3:0] step_d [8] = '{4'd2, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0, 4'd9, 4'd9};

  initial begin
    int b;
    bus.ena = 1'b1; bus.cmd_start = 1'b0; bus.cmd_stop = 1'b0;
    bus.cmd_step = 1'b0; bus.cmd_clear = 1'b0; bus.dir_up = 1'b1; bus.rate_sel = 3'd0;

    // Reset state, then 50 idle cycles with no commands.
    for (int c = 1; c <= 3; c++) exp_at(c, 0, 0, 0, 0, "reset");
    go_to(3);
    rst = 1'b0;
    b = cyc;
    for (int o = 1; o <= 50; o++) exp_at(b + o, 0, 0, 0, 0, "idle");
    go_to(b + 50);

    // Start, count up every 4 clocks, wrap 9->0 on the 10th advance, on to 3.
    b = cyc;
    for (int o = 1; o <= 54; o++) exp_at(b + o, ((o - 1) / 4) % 10, 0, 1, o == 41, "count_up");
    bus.dir_up = 1'b1; bus.cmd_start = 1'b1;
    go_to(b + 1); bus.cmd_start = 1'b0;
    go_to(b + 54);

    // Stop at 3, hold 100 cycles; step down 3->2->1->0->9 (wrap).
    b = cyc;
    for (int o = 1; o <= 100; o++) exp_at(b + o, 3, 1, 0, 0, "paused");
    for (int o = 101; o <= 108; o++) exp_at(b + o, int'(step_d[o - 101]), 1, 0, o == 107, "step_down");
    bus.cmd_stop = 1'b1;
    go_to(b + 1); bus.cmd_stop = 1'b0;
    go_to(b + 100);
    bus.dir_up = 1'b0;
    for (int j = 0; j < 4; j++) begin
      bus.cmd_step = 1'b1; go_to(cyc + 1);
      bus.cmd_step = 1'b0; go_to(cyc + 1);
    end

    // Restart from 9 upward, clear+start together at 6, then a lone start.
    b = cyc;
    for (int o = 1; o <= 4; o++)   exp_at(b + o, 9, 0, 1, 0, "restart");
    exp_at(b + 5, 0, 0, 1, 1, "restart_wrap");
    for (int o = 6; o <= 30; o++)  exp_at(b + o, (o - 5) / 4, 0, 1, 0, "restart");
    for (int o = 31; o <= 34; o++) exp_at(b + o, 0, 0, 0, 0, "clear_start");
    for (int o = 35; o <= 38; o++) exp_at(b + o, 0, 0, 1, 0, "resume");
    exp_at(b + 39, 1, 0, 1, 0, "resume");
    bus.dir_up = 1'b1; bus.cmd_start = 1'b1;
    go_to(b + 1);  bus.cmd_start = 1'b0;
    go_to(b + 30); bus.cmd_clear = 1'b1; bus.cmd_start = 1'b1;
    go_to(b + 31); bus.cmd_clear = 1'b0; bus.cmd_start = 1'b0;
    go_to(b + 34); bus.cmd_start = 1'b1;
    go_to(b + 35); bus.cmd_start = 1'b0;
    go_to(b + 39);

    // rate_sel 3 -> 0 at count 20, ena freeze with commands, async reset at 7.
    b = cyc;
    for (int o = 1; o <= 20; o++)  exp_at(b + o, 1, 0, 1, 0, "rate3");
    for (int o = 21; o <= 24; o++) exp_at(b + o, 2, 0, 1, 0, "rate0");
    exp_at(b + 25, 3, 0, 1, 0, "rate0");
    for (int o = 26; o <= 68; o++) exp_at(b + o, 3, 0, 1, 0, "ena_off");
    exp_at(b + 69, 4, 0, 1, 0, "ena_on");
    for (int o = 70; o <= 81; o++) exp_at(b + o, 4 + (o - 69) / 4, 0, 1, 0, "pre_rst");
    exp_at(b + 82, 0, 0, 0, 0, "async_rst");
    for (int o = 83; o <= 104; o++) exp_at(b + o, 0, 0, 0, 0, "post_rst");
    for (int o = 105; o <= 108; o++) exp_at(b + o, 0, 0, 1, 0, "restart2");
    exp_at(b + 109, 1, 0, 1, 0, "restart2");
    bus.rate_sel = 3'd3;
    go_to(b + 20); bus.rate_sel = 3'd0;
    go_to(b + 25); bus.ena = 1'b0;
    go_to(b + 30); bus.cmd_stop = 1'b1;
    go_to(b + 31); bus.cmd_stop = 1'b0;
    go_to(b + 40); bus.cmd_clear = 1'b1; bus.cmd_step = 1'b1;
    go_to(b + 41); bus.cmd_clear = 1'b0; bus.cmd_step = 1'b0;
    go_to(b + 50); bus.cmd_start = 1'b1;
    go_to(b + 51); bus.cmd_start = 1'b0;
    go_to(b + 60); bus.cmd_clear = 1'b1;
    go_to(b + 65); bus.ena = 1'b1;
    go_to(b + 70); bus.cmd_clear = 1'b0;
    go_to(b + 82);
    #1 rst = 1'b1;
    go_to(b + 84); rst = 1'b0;
    go_to(b + 104); bus.cmd_start = 1'b1;
    go_to(b + 105); bus.cmd_start = 1'b0;
    go_to(b + 111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
